// File: rtl/arbiter_n_rr.sv
// Registered N-input valid/ready round-robin arbiter with a 2-entry output skid buffer.
// Define CICERO_ARBITER_OVERRIDE_PRIORITY_EN to give input 0 absolute priority over the rest.
module arbiter_n_rr #(
    parameter int N_IN   = 4,
    parameter int DWIDTH = 9,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN*DWIDTH-1:0]   in_data,
    output logic [N_IN-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DWIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]         out_src,
    input  logic                     out_ready,
    output logic [1:0]               occupancy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
`ifdef CICERO_ARBITER_OVERRIDE_PRIORITY_EN
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(1);
    localparam logic [IDX_W-1:0] PTR_WRAP = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] PTR_RST  = '0;
    localparam logic [IDX_W-1:0] PTR_WRAP = '0;
`endif

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              win_found;
    logic              accept_ok;
    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] win_data;
    int                cand;

    // Entry 0 is always the head; entry 1 is the second-oldest.
    logic [DWIDTH-1:0] buf_data [2];
    logic [IDX_W-1:0]  buf_src  [2];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        in_ready  = '0;
        win_data  = '0;
        // Decision uses registered occupancy only, so out_ready never reaches in_ready.
        accept_ok = rst && (occupancy != 2'd2);
`ifdef CICERO_ARBITER_OVERRIDE_PRIORITY_EN
        if (in_valid[0]) begin
            win_found = 1'b1;
        end else begin
            for (int k = 0; k < N_IN - 1; k++) begin
                cand     = 1 + ((int'(ptr) - 1 + k) % (N_IN - 1));
                cand_idx = IDX_W'(cand);
                if (!win_found && in_valid[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end
`else
        for (int k = 0; k < N_IN; k++) begin
            cand     = (int'(ptr) + k) % N_IN;
            cand_idx = IDX_W'(cand);
            if (!win_found && in_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
`endif
        if (accept_ok && win_found) begin
            in_ready[win_idx] = 1'b1;
        end
        for (int i = 0; i < N_IN; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign push      = |in_ready;
    assign out_valid = (occupancy != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_data[0];
    assign out_src   = buf_src[0];

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr         <= PTR_RST;
            occupancy   <= 2'd0;
            // NOTE: the buffer entries are reset because the head drives out_data, which must read zero after reset.
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_src[0]  <= '0;
            buf_src[1]  <= '0;
        end else begin
            if (push) begin
`ifdef CICERO_ARBITER_OVERRIDE_PRIORITY_EN
                if (win_idx != '0) begin
                    ptr <= (win_idx == LAST_IDX) ? PTR_WRAP : win_idx + IDX_W'(1);
                end
`else
                ptr <= (win_idx == LAST_IDX) ? PTR_WRAP : win_idx + IDX_W'(1);
`endif
            end
            case ({push, pop})
                2'b10: begin
                    if (occupancy == 2'd0) begin
                        buf_data[0] <= win_data;
                        buf_src[0]  <= win_idx;
                    end else begin
                        buf_data[1] <= win_data;
                        buf_src[1]  <= win_idx;
                    end
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_src[0]  <= buf_src[1];
                    occupancy   <= occupancy - 2'd1;
                end
                2'b11: begin
                    // Push is only possible below full, so a concurrent pop means occupancy is 1.
                    buf_data[0] <= win_data;
                    buf_src[0]  <= win_idx;
                end
                default: ;
            endcase
        end
    end

endmodule
